// File: rtl/full_sub.sv
// Registered full subtractor: diff = A - B - bi with borrow-out and signed overflow.
// The borrow of each accepted operation is kept so the next one can chain from it.
module full_sub #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic             chain_en,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Bin,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic             overflow,
  output logic             out_valid
);

  localparam int unsigned XW = WIDTH + 1;

  logic             bq;
  logic             bi_c;
  logic [XW-1:0]    wide_c;
  logic [WIDTH-1:0] diff_c;
  logic             borrow_c;
  logic             ovf_c;

  // One extra bit on top catches the unsigned borrow without truncating B + bi.
  always_comb begin
    bi_c     = chain_en ? bq : Bin;
    wide_c   = {1'b0, A} - {1'b0, B} - XW'(bi_c);
    diff_c   = wide_c[WIDTH-1:0];
    borrow_c = wide_c[WIDTH];
    ovf_c    = (A[WIDTH-1] != B[WIDTH-1]) && (diff_c[WIDTH-1] != A[WIDTH-1]);
  end

  // Results and chain borrow update only on accepted operations; idle cycles hold them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      diff      <= '0;
      borrow    <= 1'b0;
      overflow  <= 1'b0;
      out_valid <= 1'b0;
      bq        <= 1'b0;
    end else if (in_valid) begin
      diff      <= diff_c;
      borrow    <= borrow_c;
      overflow  <= ovf_c;
      out_valid <= 1'b1;
      bq        <= borrow_c;
    end else begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_full_sub.sv
// Scoreboard bench for full_sub: a 1-bit and an 8-bit instance checked against an
// integer-arithmetic reference model, with latency enforced through a due-cycle stamp.
module tb_full_sub;

  typedef struct {
    longint diff;
    bit     borrow;
    bit     ovf;
    int     due;
  } res_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;

  logic       v1, ch1, bin1;
  logic [0:0] a1, b1, d1;
  logic       bo1, of1, ov1;

  logic       v8, ch8, bin8;
  logic [7:0] a8, b8, d8;
  logic       bo8, of8, ov8;

  int   cyc = 0;
  int   n_cmp = 0;
  int   n_err = 0;
  res_t q1[$];
  res_t q8[$];
  res_t last1, last8, zero_r;
  bit   bq1 = 1'b0;
  bit   bq8 = 1'b0;

  full_sub #(.WIDTH(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(v1), .chain_en(ch1),
    .A(a1), .B(b1), .Bin(bin1),
    .diff(d1), .borrow(bo1), .overflow(of1), .out_valid(ov1)
  );

  full_sub #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(v8), .chain_en(ch8),
    .A(a8), .B(b8), .Bin(bin8),
    .diff(d8), .borrow(bo8), .overflow(of8), .out_valid(ov8)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc = cyc + 1;

  // Reference: plain integer subtraction, signed overflow as "true result out of range".
  function automatic res_t model(input int w, input longint a, input longint b, input bit bi);
    res_t   r;
    longint m, half, sa, sb, s;
    m        = longint'(1) << w;
    half     = m / 2;
    r.diff   = (a - b - longint'(bi) + m) % m;
    r.borrow = (a < b + longint'(bi));
    sa       = (a >= half) ? a - m : a;
    sb       = (b >= half) ? b - m : b;
    s        = sa - sb - longint'(bi);
    r.ovf    = (s < -half) || (s >= half);
    r.due    = 0;
    return r;
  endfunction

  task automatic chk(input string nm, input logic ov, input logic ov_exp,
                     input logic [63:0] d, input logic b, input logic o, input res_t e);
    n_cmp++;
    if (ov !== ov_exp || d !== 64'(e.diff) || b !== e.borrow || o !== e.ovf) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got valid=%b diff=%0h borrow=%b ovf=%b, want valid=%b diff=%0h borrow=%b ovf=%b",
               nm, cyc, ov, d, b, o, ov_exp, e.diff, e.borrow, e.ovf);
    end
  endtask

  // Monitor: an entry due this cycle must be presented; otherwise out_valid=0 and values hold.
  always @(negedge clk) begin
    res_t e;
    if (rst_n) begin
      if (q1.size() > 0 && q1[0].due == cyc) begin
        e = q1.pop_front();
        last1 = e;
        chk("w1_result", ov1, 1'b1, 64'(d1), bo1, of1, e);
      end else begin
        chk("w1_hold", ov1, 1'b0, 64'(d1), bo1, of1, last1);
      end
      if (q8.size() > 0 && q8[0].due == cyc) begin
        e = q8.pop_front();
        last8 = e;
        chk("w8_result", ov8, 1'b1, 64'(d8), bo8, of8, e);
      end else begin
        chk("w8_hold", ov8, 1'b0, 64'(d8), bo8, of8, last8);
      end
    end
  end

  task automatic idle_all();
    v1 = 1'b0; ch1 = 1'b0; bin1 = 1'b0; a1 = '0; b1 = '0;
    v8 = 1'b0; ch8 = 1'b0; bin8 = 1'b0; a8 = '0; b8 = '0;
  endtask

  task automatic set1(input longint a, input longint b, input bit bin, input bit ch);
    res_t e;
    e     = model(1, a, b, ch ? bq1 : bin);
    e.due = cyc + 1;
    q1.push_back(e);
    bq1   = e.borrow;
    v1 = 1'b1; a1 = 1'(a); b1 = 1'(b); bin1 = bin; ch1 = ch;
  endtask

  task automatic set8(input longint a, input longint b, input bit bin, input bit ch);
    res_t e;
    e     = model(8, a, b, ch ? bq8 : bin);
    e.due = cyc + 1;
    q8.push_back(e);
    bq8   = e.borrow;
    v8 = 1'b1; a8 = 8'(a); b8 = 8'(b); bin8 = bin; ch8 = ch;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit [2:0] tv;
    zero_r = '{diff: 0, borrow: 1'b0, ovf: 1'b0, due: 0};
    last1  = zero_r;
    last8  = zero_r;
    idle_all();
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    repeat (2) begin @(negedge clk); idle_all(); end

    // 1-bit truth table, back to back
    for (int i = 0; i < 8; i++) begin
      @(negedge clk); idle_all();
      case (i)
        0: tv = 3'b000; 1: tv = 3'b001; 2: tv = 3'b010; 3: tv = 3'b100;
        4: tv = 3'b110; 5: tv = 3'b101; 6: tv = 3'b011; default: tv = 3'b111;
      endcase
      set1(longint'(tv[2]), longint'(tv[1]), tv[0], 1'b0);
    end

    // Asynchronous reset mid-cycle after a borrowing operation
    @(negedge clk); idle_all(); set1(0, 1, 1'b0, 1'b0);
    @(negedge clk); idle_all();
    #2 rst_n = 1'b0;
    #1;
    chk("rst_async_w1", ov1, 1'b0, 64'(d1), bo1, of1, zero_r);
    chk("rst_async_w8", ov8, 1'b0, 64'(d8), bo8, of8, zero_r);
    q1.delete(); q8.delete();
    last1 = zero_r; last8 = zero_r; bq1 = 1'b0; bq8 = 1'b0;
    @(posedge clk); #2 rst_n = 1'b1;
    @(negedge clk); idle_all(); set1(1, 0, 1'b1, 1'b1);
    @(negedge clk); idle_all(); set8(5, 7, 1'b0, 1'b1);

    // 16-bit subtraction 0x0500 - 0x0201 split across two chained words
    @(negedge clk); idle_all(); set8(8'h00, 8'h01, 1'b0, 1'b0);
    @(negedge clk); idle_all(); set8(8'h05, 8'h02, 1'b0, 1'b1);

    // Signed overflow and boundary cases
    @(negedge clk); idle_all(); set8(8'h80, 8'h01, 1'b0, 1'b0);
    @(negedge clk); idle_all(); set8(8'h7F, 8'hFF, 1'b0, 1'b0);
    @(negedge clk); idle_all(); set8(8'h10, 8'h10, 1'b1, 1'b0);
    @(negedge clk); idle_all(); set8(8'h00, 8'hFF, 1'b1, 1'b0);
    @(negedge clk); idle_all(); set8(8'h33, 8'h33, 1'b0, 1'b0);
    @(negedge clk); idle_all(); set8(8'h33, 8'h33, 1'b1, 1'b0);
    @(negedge clk); idle_all(); set8(8'h00, 8'h00, 1'b1, 1'b1);

    // Hold with unknown operands while idle, then chain from the held borrow
    @(negedge clk); idle_all(); set8(8'h03, 8'h01, 1'b0, 1'b0);
    repeat (3) begin
      @(negedge clk); idle_all();
      a8 = 'x; b8 = 'x; bin8 = 1'bx; ch8 = 1'bx;
      a1 = 'x; b1 = 'x; bin1 = 1'bx; ch1 = 1'bx;
    end
    @(negedge clk); idle_all(); set8(8'h07, 8'h02, 1'b1, 1'b1);

    // Back-to-back random traffic on both widths
    for (int i = 0; i < 16; i++) begin
      @(negedge clk); idle_all();
      set8(longint'($urandom_range(255)), longint'($urandom_range(255)),
           1'($urandom_range(1)), 1'($urandom_range(1)));
      set1(longint'($urandom_range(1)), longint'($urandom_range(1)),
           1'($urandom_range(1)), 1'($urandom_range(1)));
    end

    // Random traffic with gaps
    for (int i = 0; i < 24; i++) begin
      @(negedge clk); idle_all();
      if ($urandom_range(3) != 0)
        set8(longint'($urandom_range(255)), longint'($urandom_range(255)),
             1'($urandom_range(1)), 1'($urandom_range(1)));
      if ($urandom_range(1) != 0)
        set1(longint'($urandom_range(1)), longint'($urandom_range(1)),
             1'($urandom_range(1)), 1'($urandom_range(1)));
    end

    repeat (3) begin @(negedge clk); idle_all(); end
    #1;
    n_cmp++;
    if (q1.size() != 0 || q8.size() != 0) begin
      n_err++;
      $display("FAIL drain: got %0d/%0d results outstanding, want 0/0", q1.size(), q8.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
